stream_demux: RTL and testbench
===============================

# stream_demux

Single-clock AXI-Stream fan-out for 112-bit BPM-link beats. It is the counterpart to the two-input link merge: one stream enters and each beat is steered by a destination mask to output port 00, output port 01, both, or neither. Each output has its own first-word-fallthrough FIFO. The block sits between the cell-controller packet source and the two outbound BPM link transmitters.

## Interface
Parameters:
- DW, 112, TDATA width.
- FIFO_AW, 4, per-output FIFO address width; depth is 2**FIFO_AW (16).
- CNT_W, 16, width of the drop counters.

Ports:
- aclk  in  1  sole clock; all logic is on its rising edge.
- areset  in  1  asynchronous, active-high reset.
- s00_tvalid  in  1  input beat valid.
- s00_tready  out  1  input beat accepted.
- s00_tdata  in  DW  input payload.
- s00_tdest  in  2  destination mask: bit0 selects m00, bit1 selects m01.
- m00_tvalid, m01_tvalid  out  1  output beat valid.
- m00_tready, m01_tready  in  1  downstream ready.
- m00_tdata, m01_tdata  out  DW  output payload.
- m00_hold, m01_hold  in  1  when high, the output's tvalid is forced low; the FIFO keeps filling.
- m00_dropped, m01_dropped  out  CNT_W  drop counts; these exist only with the drop feature and are 0 otherwise.

## Operation
- Handshake: an input beat transfers when s00_tvalid and s00_tready are both high on a rising edge. The beat is written to every FIFO whose tdest bit is set.
- tdest = 2'b00: the beat is accepted (s00_tready = 1) and discarded. It is not counted as a drop.
- Backpressure mode (default): s00_tready = ~((tdest[0] & full0) | (tdest[1] & full1)).
  - full is the registered FIFO state. A pop in the same cycle does not free space for that cycle's push.
  - A broadcast beat is written to both FIFOs atomically or to neither.
- Output n: mN_tvalid = ~emptyN & ~mN_hold, and mN_tdata = FIFO head. The FIFO pops when mN_tvalid and mN_tready are both high.
- tdata must stay stable while tvalid is high and the beat is not accepted. This holds on the input side and is guaranteed on the output side.
- FIFO occupancy counts from 0 to 2**FIFO_AW. Pointers carry one extra wrap bit.
  - full = (pointer addresses equal) and (wrap bits differ).
  - empty = full pointers equal.
- Simultaneous push and pop on a non-empty FIFO leaves occupancy unchanged. The order of beats is preserved per output.
- hold asserted mid-stream drops tvalid in the same cycle and pops nothing. Deasserting hold presents the same head beat.

## Timing
- Values during reset: s00_tready = 0; m00_tvalid and m01_tvalid = 0; pointers = 0; drop counters = 0; mN_tdata = don't-care.
- First cycle after release: s00_tready follows the formula above (1 for any tdest, since both FIFOs are empty).
- Latency: a beat accepted at edge N shows on mN_tvalid and mN_tdata after edge N, i.e. in cycle N+1.
- Throughput: one beat per cycle per output when the downstream is always ready.
- s00_tready is combinational from s00_tdest and the registered full flags. There is no path from mN_tready to s00_tready.
- Asynchronous reset mid-operation clears both FIFOs immediately. Beats in flight are lost and are not counted.

## Configuration
- STREAM_DEMUX_DROP_EN defined:
  - s00_tready is held at 1 whenever the block is out of reset.
  - A beat bound for a full FIFO is discarded for that output only. The other targeted output still receives it.
  - mN_dropped increments by 1 for each discarded beat and saturates at 2**CNT_W-1.
- STREAM_DEMUX_DROP_EN undefined:
  - Backpressure as described under Operation.
  - The counters are not synthesized and m00_dropped and m01_dropped are tied to 0.

## Structure
- Package stream_demux_pkg holds:
  - constants BPM_DW = 112 and DEST_M00 = 2'b01, DEST_M01 = 2'b10, DEST_BOTH = 2'b11;
  - typedef dest_t (logic [1:0]).
- Sub-module sync_fwft_fifo (DW, AW): single-clock first-word-fallthrough FIFO with asynchronous active-high reset.
  - Ports: push, pop, din, dout, full, empty.
  - Instantiated twice.
- The top level contains the steering logic, the hold gating and the optional drop counters.

## Test plan
- Reset, then one beat 0xA5 with tdest = 01 and m00_tready = 1 → m00_tvalid high for exactly one cycle with data 0xA5 in the cycle after acceptance; m01_tvalid stays 0.
- Broadcast of 3 beats (1, 2, 3) with tdest = 11, m00 ready and m01 ready low → m00 emits 1, 2, 3; after m01_tready is raised, m01 emits 1, 2, 3 in order.
- Backpressure mode: fill m01 with 16 beats while m01_tready = 0, then present a broadcast beat → s00_tready = 0, and m00 does not receive the beat until m01 pops.
- STREAM_DEMUX_DROP_EN defined: 20 beats to a blocked m00 → s00_tready stays 1, m00_dropped = 4, and the 16 stored beats are the first 16 sent.
- m01_hold pulsed for 5 cycles mid-stream → m01_tvalid is low for those 5 cycles; no beat is lost or duplicated and the head beat is unchanged afterward.
- areset asserted with 8 beats queued in each FIFO → both mN_tvalid go low asynchronously; after release, both FIFOs are empty and the counters read 0.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the BPM-link stream demultiplexer.
package stream_demux_pkg;

    localparam int BPM_DW = 112;

    typedef logic [1:0] dest_t;

    localparam dest_t DEST_M00  = 2'b01;
    localparam dest_t DEST_M01  = 2'b10;
    localparam dest_t DEST_BOTH = 2'b11;

endpackage

// File: rtl/stream_demux_if.sv
// Stream-side bundle of stream_demux: one input stream, two output streams, hold inputs and drop counts.
// The master modport is the surroundings (source and sinks); the slave modport is the demux itself.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int DW    = BPM_DW,
    parameter int CNT_W = 16
) ();

    logic              s00_tvalid;
    logic              s00_tready;
    logic [DW-1:0]     s00_tdata;
    dest_t             s00_tdest;

    logic              m00_tvalid;
    logic              m00_tready;
    logic [DW-1:0]     m00_tdata;
    logic              m00_hold;
    logic [CNT_W-1:0]  m00_dropped;

    logic              m01_tvalid;
    logic              m01_tready;
    logic [DW-1:0]     m01_tdata;
    logic              m01_hold;
    logic [CNT_W-1:0]  m01_dropped;

    modport master (
        output s00_tvalid, s00_tdata, s00_tdest,
        input  s00_tready,
        input  m00_tvalid, m00_tdata, m00_dropped,
        output m00_tready, m00_hold,
        input  m01_tvalid, m01_tdata, m01_dropped,
        output m01_tready, m01_hold
    );

    modport slave (
        input  s00_tvalid, s00_tdata, s00_tdest,
        output s00_tready,
        output m00_tvalid, m00_tdata, m00_dropped,
        input  m00_tready, m00_hold,
        output m01_tvalid, m01_tdata, m01_dropped,
        input  m01_tready, m01_hold
    );

endinterface

// File: rtl/stream_demux_fifo.sv
// sync_fwft_fifo: single-clock first-word-fallthrough FIFO, depth 2**AW, async active-high reset.
// Pointers carry an extra wrap bit so full and empty are told apart without a separate count.
module sync_fwft_fifo #(
    parameter int DW = 112,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] r_mem [2**AW];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push;
    logic          w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is visible until the write pointer moves past it.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/stream_demux.sv
// stream_demux: steers each input beat to m00, m01, both or neither by tdest mask, one FWFT FIFO per output.
// Optional feature STREAM_DEMUX_DROP_EN: never backpressure, discard per-output on full and count drops.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DW      = BPM_DW,
    parameter int FIFO_AW = 4,
    parameter int CNT_W   = 16
) (
    input  logic          aclk,
    input  logic          areset,
    stream_demux_if.slave bus
);

    logic w_sel0, w_sel1;
    logic w_full0, w_full1;
    logic w_empty0, w_empty1;
    logic w_xfer;
    logic w_push0, w_push1;
    logic w_pop0, w_pop1;

    assign w_sel0 = |(bus.s00_tdest & DEST_M00);
    assign w_sel1 = |(bus.s00_tdest & DEST_M01);
    assign w_xfer = bus.s00_tvalid & bus.s00_tready;

`ifdef STREAM_DEMUX_DROP_EN
    logic             w_drop0, w_drop1;
    logic [CNT_W-1:0] r_dropped0, r_dropped1;

    assign bus.s00_tready = ~areset;
    assign w_push0 = w_xfer & w_sel0 & ~w_full0;
    assign w_push1 = w_xfer & w_sel1 & ~w_full1;
    assign w_drop0 = w_xfer & w_sel0 & w_full0;
    assign w_drop1 = w_xfer & w_sel1 & w_full1;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_dropped0 <= '0;
            r_dropped1 <= '0;
        end else begin
            if (w_drop0 && (r_dropped0 != '1)) r_dropped0 <= r_dropped0 + CNT_W'(1);
            if (w_drop1 && (r_dropped1 != '1)) r_dropped1 <= r_dropped1 + CNT_W'(1);
        end
    end

    assign bus.m00_dropped = r_dropped0;
    assign bus.m01_dropped = r_dropped1;
`else
    // A broadcast stalls unless both targets have room, so it lands in both FIFOs or neither.
    assign bus.s00_tready = ~areset & ~((w_sel0 & w_full0) | (w_sel1 & w_full1));
    assign w_push0 = w_xfer & w_sel0;
    assign w_push1 = w_xfer & w_sel1;

    assign bus.m00_dropped = '0;
    assign bus.m01_dropped = '0;
`endif

    assign bus.m00_tvalid = ~w_empty0 & ~bus.m00_hold;
    assign bus.m01_tvalid = ~w_empty1 & ~bus.m01_hold;
    assign w_pop0 = bus.m00_tvalid & bus.m00_tready;
    assign w_pop1 = bus.m01_tvalid & bus.m01_tready;

    sync_fwft_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo0 (
        .clk   (aclk),
        .rst   (areset),
        .push  (w_push0),
        .pop   (w_pop0),
        .din   (bus.s00_tdata),
        .dout  (bus.m00_tdata),
        .full  (w_full0),
        .empty (w_empty0)
    );

    sync_fwft_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo1 (
        .clk   (aclk),
        .rst   (areset),
        .push  (w_push1),
        .pop   (w_pop1),
        .din   (bus.s00_tdata),
        .dout  (bus.m01_tdata),
        .full  (w_full1),
        .empty (w_empty1)
    );

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux; the STREAM_DEMUX_DROP_EN build swaps the backpressure test for the drop test.
module tb_stream_demux;
    import stream_demux_pkg::*;

    logic aclk   = 1'b0;
    logic areset = 1'b0;

    always #5 aclk = ~aclk;

    stream_demux_if #(.DW(BPM_DW), .CNT_W(16)) bus ();

    stream_demux #(.DW(BPM_DW), .FIFO_AW(4), .CNT_W(16)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] q[$];
    logic exp_pop;
    logic exp_push;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic mid();
        @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        bus.s00_tvalid = 1'b0;
        bus.s00_tdata  = '0;
        bus.s00_tdest  = DEST_BOTH;
        bus.m00_tready = 1'b0;
        bus.m01_tready = 1'b0;
        bus.m00_hold   = 1'b0;
        bus.m01_hold   = 1'b0;

        // Reset values
        #2 areset = 1'b1;
        repeat (2) step();
        check_eq("rst_tready", bus.s00_tready, 0);
        check_eq("rst_m00_tvalid", bus.m00_tvalid, 0);
        check_eq("rst_m01_tvalid", bus.m01_tvalid, 0);
        check_eq("rst_m00_dropped", bus.m00_dropped, 0);
        check_eq("rst_m01_dropped", bus.m01_dropped, 0);
        areset = 1'b0;
        #1;
        check_eq("rel_tready_both", bus.s00_tready, 1);
        bus.s00_tdest = 2'b00;
        #1;
        check_eq("rel_tready_none", bus.s00_tready, 1);

        // Single beat to m00
        bus.s00_tvalid = 1'b1;
        bus.s00_tdest  = DEST_M00;
        bus.s00_tdata  = 'hA5;
        bus.m00_tready = 1'b1;
        mid();
        check_eq("t1_tready", bus.s00_tready, 1);
        step();
        bus.s00_tvalid = 1'b0;
        mid();
        check_eq("t1_m00_tvalid", bus.m00_tvalid, 1);
        check_eq("t1_m00_tdata", bus.m00_tdata, 'hA5);
        check_eq("t1_m01_tvalid", bus.m01_tvalid, 0);
        step();
        mid();
        check_eq("t1_m00_once", bus.m00_tvalid, 0);

        // tdest 00 is accepted and discarded
        bus.s00_tvalid = 1'b1;
        bus.s00_tdest  = 2'b00;
        bus.s00_tdata  = 'h77;
        #1;
        check_eq("none_tready", bus.s00_tready, 1);
        step();
        bus.s00_tvalid = 1'b0;
        mid();
        check_eq("none_m00_tvalid", bus.m00_tvalid, 0);
        check_eq("none_m01_tvalid", bus.m01_tvalid, 0);

        // Broadcast 1,2,3 with m01 stalled
        bus.m00_tready = 1'b1;
        bus.m01_tready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.s00_tvalid = 1'b1;
            bus.s00_tdest  = DEST_BOTH;
            bus.s00_tdata  = 128'(k);
            step();
            mid();
            check_eq("bc_m00_tvalid", bus.m00_tvalid, 1);
            check_eq("bc_m00_tdata", bus.m00_tdata, 128'(k));
        end
        bus.s00_tvalid = 1'b0;
        step();
        mid();
        check_eq("bc_m00_drained", bus.m00_tvalid, 0);
        bus.m01_tready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            check_eq("bc_m01_tvalid", bus.m01_tvalid, 1);
            check_eq("bc_m01_tdata", bus.m01_tdata, 128'(k));
            step();
            mid();
        end
        check_eq("bc_m01_drained", bus.m01_tvalid, 0);
        bus.m01_tready = 1'b0;

`ifndef STREAM_DEMUX_DROP_EN
        // Backpressure: m01 full blocks a broadcast until m01 pops
        for (int i = 0; i < 16; i++) begin
            bus.s00_tvalid = 1'b1;
            bus.s00_tdest  = DEST_M01;
            bus.s00_tdata  = 128'('h100 + i);
            step();
        end
        bus.s00_tdest  = DEST_BOTH;
        bus.s00_tdata  = 'hBB;
        bus.m00_tready = 1'b1;
        #1;
        check_eq("bp_tready_full", bus.s00_tready, 0);
        mid();
        check_eq("bp_m00_empty", bus.m00_tvalid, 0);
        bus.s00_tdest = DEST_M00;
        #1;
        check_eq("bp_tready_m00_only", bus.s00_tready, 1);
        bus.s00_tdest  = DEST_BOTH;
        bus.m01_tready = 1'b1;
        #1;
        check_eq("bp_no_ready_path", bus.s00_tready, 0);
        step();
        mid();
        check_eq("bp_tready_freed", bus.s00_tready, 1);
        check_eq("bp_m00_still_empty", bus.m00_tvalid, 0);
        check_eq("bp_m01_head", bus.m01_tdata, 'h101);
        step();
        bus.s00_tvalid = 1'b0;
        mid();
        check_eq("bp_m00_tvalid", bus.m00_tvalid, 1);
        check_eq("bp_m00_tdata", bus.m00_tdata, 'hBB);
        for (int i = 2; i < 16; i++) begin
            check_eq("bp_m01_order", bus.m01_tdata, 128'('h100 + i));
            step();
            mid();
        end
        check_eq("bp_m01_last", bus.m01_tdata, 'hBB);
        step();
        mid();
        check_eq("bp_m01_drained", bus.m01_tvalid, 0);
        check_eq("bp_m00_drained", bus.m00_tvalid, 0);
        bus.m00_tready = 1'b0;
        bus.m01_tready = 1'b0;
`else
        // Drop mode: 20 beats into a blocked m00
        bus.m00_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.s00_tvalid = 1'b1;
            bus.s00_tdest  = DEST_M00;
            bus.s00_tdata  = 128'('h300 + i);
            #1;
            check_eq("drop_tready", bus.s00_tready, 1);
            step();
        end
        bus.s00_tvalid = 1'b0;
        mid();
        check_eq("drop_m00_count", bus.m00_dropped, 4);
        check_eq("drop_m01_count", bus.m01_dropped, 0);
        bus.m00_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("drop_m00_order", bus.m00_tdata, 128'('h300 + i));
            step();
            mid();
        end
        check_eq("drop_m00_drained", bus.m00_tvalid, 0);
        bus.m00_tready = 1'b0;
`endif

        // m01 hold pulsed mid-stream; reference queue models m01 contents
        mid();
        q.delete();
        bus.m01_tready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.s00_tvalid = (c < 10);
            bus.s00_tdest  = DEST_M01;
            bus.s00_tdata  = 128'('h200 + c);
            bus.m01_hold   = (c >= 3 && c < 8);
            #1;
            exp_pop  = (q.size() > 0) && !bus.m01_hold;
            exp_push = bus.s00_tvalid;
            check_eq("hold_m01_tvalid", bus.m01_tvalid, exp_pop);
            if (exp_pop) check_eq("hold_m01_tdata", bus.m01_tdata, q[0]);
            if (exp_push) check_eq("hold_tready", bus.s00_tready, 1);
            step();
            if (exp_pop) void'(q.pop_front());
            if (exp_push) q.push_back(128'('h200 + c));
            mid();
        end
        bus.m01_hold = 1'b0;
        #1;
        check_eq("hold_drained", bus.m01_tvalid, 0);
        bus.m01_tready = 1'b0;

        // Async reset with 8 beats queued in each FIFO
        for (int i = 0; i < 8; i++) begin
            bus.s00_tvalid = 1'b1;
            bus.s00_tdest  = DEST_BOTH;
            bus.s00_tdata  = 128'('h400 + i);
            step();
        end
        bus.s00_tvalid = 1'b0;
        mid();
        check_eq("ar_m00_head", bus.m00_tdata, 'h400);
        check_eq("ar_m01_head", bus.m01_tdata, 'h400);
        check_eq("ar_m00_pre", bus.m00_tvalid, 1);
        #1 areset = 1'b1;
        #1;
        check_eq("ar_m00_tvalid", bus.m00_tvalid, 0);
        check_eq("ar_m01_tvalid", bus.m01_tvalid, 0);
        check_eq("ar_tready", bus.s00_tready, 0);
        step();
        step();
        areset = 1'b0;
        #1;
        check_eq("ar_rel_m00_tvalid", bus.m00_tvalid, 0);
        check_eq("ar_rel_m01_tvalid", bus.m01_tvalid, 0);
        check_eq("ar_rel_m00_dropped", bus.m00_dropped, 0);
        check_eq("ar_rel_m01_dropped", bus.m01_dropped, 0);
        check_eq("ar_rel_tready", bus.s00_tready, 1);
        bus.s00_tvalid = 1'b1;
        bus.s00_tdest  = DEST_M00;
        bus.s00_tdata  = 'h500;
        bus.m00_tready = 1'b1;
        step();
        bus.s00_tvalid = 1'b0;
        mid();
        check_eq("ar_fresh_tdata", bus.m00_tdata, 'h500);
        check_eq("ar_fresh_m01", bus.m01_tvalid, 0);
        step();
        mid();
        check_eq("ar_fresh_drained", bus.m00_tvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
